// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Write enables and retire are held low while reset is asserted.
module multicycle_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   output logic               pcen,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regwrite,
   output logic               iord,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic               regdst,
   output logic               memtoreg,
   output logic [2:0]         alucontrol,
   output logic               retire,
   output logic [STATE_W-1:0] dbg_state
);

   localparam logic [STATE_W-1:0] FETCH   = STATE_W'(0);
   localparam logic [STATE_W-1:0] DECODE  = STATE_W'(1);
   localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(2);
   localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(3);
   localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(4);
   localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(5);
   localparam logic [STATE_W-1:0] EXECUTE = STATE_W'(6);
   localparam logic [STATE_W-1:0] ALUWB   = STATE_W'(7);
   localparam logic [STATE_W-1:0] BRANCH  = STATE_W'(8);
   localparam logic [STATE_W-1:0] ADDIEX  = STATE_W'(9);
   localparam logic [STATE_W-1:0] ADDIWB  = STATE_W'(10);
   localparam logic [STATE_W-1:0] JUMP    = STATE_W'(11);

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [STATE_W-1:0] state, next_state;
   logic [1:0]         aluop;
   logic               pcwrite, branch;
   logic               memwrite_s, irwrite_s, regwrite_s, retire_s;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   // op is only meaningful from DECODE onward, after FETCH has loaded the IR
   always_comb begin
      next_state = FETCH;
      case (state)
         FETCH:   next_state = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_RTYPE:     next_state = EXECUTE;
               OP_BEQ:       next_state = BRANCH;
               OP_ADDI:      next_state = ADDIEX;
               OP_J:         next_state = JUMP;
               default:      next_state = FETCH;
            endcase
         end
         MEMADR:  next_state = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   next_state = MEMWB;
         EXECUTE: next_state = ALUWB;
         ADDIEX:  next_state = ADDIWB;
         default: next_state = FETCH;
      endcase
   end

   always_comb begin
      irwrite_s  = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      memwrite_s = 1'b0;
      regwrite_s = 1'b0;
      retire_s   = 1'b0;
      iord       = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      aluop      = 2'b00;
      case (state)
         FETCH: begin
            irwrite_s = 1'b1;
            pcwrite   = 1'b1;
            alusrcb   = 2'b01;
         end
         DECODE:  alusrcb = 2'b11;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD:   iord = 1'b1;
         MEMWB: begin
            regwrite_s = 1'b1;
            memtoreg   = 1'b1;
            retire_s   = 1'b1;
         end
         MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
            retire_s   = 1'b1;
         end
         EXECUTE: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         ALUWB: begin
            regwrite_s = 1'b1;
            regdst     = 1'b1;
            retire_s   = 1'b1;
         end
         BRANCH: begin
            alusrca  = 1'b1;
            aluop    = 2'b01;
            pcsrc    = 2'b01;
            branch   = 1'b1;
            retire_s = 1'b1;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ADDIWB: begin
            regwrite_s = 1'b1;
            retire_s   = 1'b1;
         end
         JUMP: begin
            pcsrc    = 2'b10;
            pcwrite  = 1'b1;
            retire_s = 1'b1;
         end
         default: ;
      endcase
   end

   // unsupported funct falls back to add so the R-type sequence still completes
   always_comb begin
      alucontrol = 3'b010;
      case (aluop)
         2'b01: alucontrol = 3'b110;
         2'b10: begin
            case (funct)
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b010;
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
   end

   assign pcen      = ~reset & (pcwrite | (branch & zero));
   assign memwrite  = ~reset & memwrite_s;
   assign irwrite   = ~reset & irwrite_s;
   assign regwrite  = ~reset & regwrite_s;
   assign retire    = ~reset & retire_s;
   assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and checks the per-state control outputs.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic       pcen, memwrite, irwrite, regwrite, iord, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic       regdst, memtoreg;
   logic [2:0] alucontrol;
   logic       retire;
   logic [3:0] dbg_state;

   int checks = 0;
   int failures = 0;
   int retires;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
      .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .regdst(regdst), .memtoreg(memtoreg), .alucontrol(alucontrol),
      .retire(retire), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then sample on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      if (retire === 1'b1) retires++;
   endtask

   task automatic check_we(input string tag);
      check({tag, "_we"}, {28'd0, memwrite, irwrite, regwrite, pcen}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      check("rst_init_state", dbg_state, 0);
      step(); step(); step();
      check("pre_rst_memrd", dbg_state, 3);

      // reset from MEMRD, held for three edges
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_state", dbg_state, 0);
         check_we("rst");
         check("rst_retire", retire, 0);
      end
      reset = 1'b0;
      #1;
      check("fetch_en", {irwrite, pcen, alusrcb, alucontrol}, {1'b1, 1'b1, 2'b01, 3'b010});

      // lw: 0,1,2,3,4,0 with exactly one retire pulse
      retires = 0;
      step(); check("lw_s1", dbg_state, 1);
      check("lw_dec", {alusrcb, alucontrol}, {2'b11, 3'b010});
      check_we("lw_dec");
      step(); check("lw_s2", dbg_state, 2);
      check("lw_memadr", {alusrca, alusrcb}, {1'b1, 2'b10});
      step(); check("lw_s3", dbg_state, 3);
      check("lw_memrd", {iord, retire, regwrite}, {1'b1, 1'b0, 1'b0});
      step(); check("lw_s4", dbg_state, 4);
      check("lw_memwb", {regwrite, memtoreg, retire, regdst}, {1'b1, 1'b1, 1'b1, 1'b0});
      step(); check("lw_s0", dbg_state, 0);
      check("lw_retires", retires, 1);

      // sw: 0,1,2,5,0
      op = 6'b101011;
      step(); check("sw_s1", dbg_state, 1);
      check("sw_mw1", memwrite, 0);
      step(); check("sw_s2", dbg_state, 2);
      check("sw_mw2", memwrite, 0);
      step(); check("sw_s5", dbg_state, 5);
      check("sw_memwr", {memwrite, iord, retire, regwrite}, {1'b1, 1'b1, 1'b1, 1'b0});
      step(); check("sw_s0", dbg_state, 0);
      check("sw_mw0", memwrite, 0);

      // R-type slt: 0,1,6,7,0
      op = 6'b000000; funct = 6'b101010;
      step(); check("slt_s1", dbg_state, 1);
      step(); check("slt_s6", dbg_state, 6);
      check("slt_exec", {alucontrol, alusrca, alusrcb}, {3'b111, 1'b1, 2'b00});
      step(); check("slt_s7", dbg_state, 7);
      check("slt_aluwb", {regwrite, regdst, memtoreg, retire}, {1'b1, 1'b1, 1'b0, 1'b1});
      step(); check("slt_s0", dbg_state, 0);

      // remaining funct decodes in EXECUTE, including unsupported -> add
      funct = 6'b100010;
      step(); step(); check("sub_alu", alucontrol, 3'b110);
      funct = 6'b100100; #1; check("and_alu", alucontrol, 3'b000);
      funct = 6'b100101; #1; check("or_alu", alucontrol, 3'b001);
      funct = 6'b000111; #1; check("bad_alu", alucontrol, 3'b010);
      step(); check("bad_s7", dbg_state, 7);
      step(); check("bad_s0", dbg_state, 0);

      // beq: zero observed combinationally in BRANCH
      op = 6'b000100; zero = 1'b1;
      step(); check("beq_s1", dbg_state, 1);
      check("beq_dec_pcen", pcen, 0);
      step(); check("beq_s8", dbg_state, 8);
      check("beq_taken", {pcen, pcsrc, alucontrol, retire}, {1'b1, 2'b01, 3'b110, 1'b1});
      zero = 1'b0; #1;
      check("beq_not_taken", pcen, 0);
      step(); check("beq_s0", dbg_state, 0);

      // j: 0,1,11,0
      op = 6'b000010;
      step(); check("j_s1", dbg_state, 1);
      step(); check("j_s11", dbg_state, 11);
      check("j_jump", {pcsrc, pcen, retire}, {2'b10, 1'b1, 1'b1});
      step(); check("j_s0", dbg_state, 0);

      // addi: 0,1,9,10,0
      op = 6'b001000;
      step(); check("addi_s1", dbg_state, 1);
      step(); check("addi_s9", dbg_state, 9);
      check("addi_ex", {alusrca, alusrcb, alucontrol, regwrite}, {1'b1, 2'b10, 3'b010, 1'b0});
      step(); check("addi_s10", dbg_state, 10);
      check("addi_wb", {regwrite, regdst, memtoreg, retire}, {1'b1, 1'b0, 1'b0, 1'b1});
      step(); check("addi_s0", dbg_state, 0);

      // unknown op: DECODE then FETCH, no writes, no retire
      op = 6'b111111; retires = 0;
      step(); check("nop_s1", dbg_state, 1);
      check_we("nop_dec");
      step(); check("nop_s0", dbg_state, 0);
      check("nop_retires", retires, 0);

      // illegal state code recovers to FETCH
      force dut.state = 4'd13;
      #1;
      check("ill_state", dbg_state, 13);
      check_we("ill");
      check("ill_retire", retire, 0);
      release dut.state;
      step(); check("ill_recover", dbg_state, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
